// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: types and constants shared by the memory port arbiter,
// its round-robin sub-block, and anything that needs to decode ownership.
//   arb_state_t : arbiter FSM state
//   requester_t : which requester owns a transaction / was granted last
//   CNT_W       : read latency counter width (covers READ_LAT 1..7)
package mem_port_arbiter_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_IF   = 1'b0,
        REQ_DATA = 1'b1
    } requester_t;

    localparam int CNT_W = 3;

    // Grant vector bit 0 is the fetch port, bit 1 is the data port.
    function automatic requester_t gnt_owner(input logic [1:0] gnt);
        requester_t owner;
        if (gnt[1]) begin
            owner = REQ_DATA;
        end else begin
            owner = REQ_IF;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the data port and the shared
// memory port of the arbiter.
//   slave  : arbiter side (takes requests and read data, drives grants,
//            read responses and the memory command)
//   master : requester/memory side (drives requests and read data)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant decode, purely combinational.
//   i_req[0]     : fetch port requesting
//   i_req[1]     : data port requesting
//   i_last_owner : requester granted most recently
//   o_gnt[1:0]   : one-hot grant (or zero when nobody requests)
module rr_arbiter_2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  requester_t i_last_owner,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   o_gnt = (i_last_owner == REQ_IF) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single memory port between an instruction-fetch
// read port and a load/store data port, one transaction in flight at a time.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high
//   bus      : mem_port_arbiter_if.slave
//              fetch : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
//              data  : d_req/d_we/d_addr/d_wdata in, d_gnt/d_rvalid/d_rdata out
//              memory: mem_addr/mem_we/mem_wdata out, mem_rdata in
//                      (read data valid READ_LAT cycles after the address)
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | grants issued combinationally; stores complete in the grant cycle
// READ_WAIT | read outstanding; no grants, counter runs down to rvalid
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    // The grant cycle itself is the first latency cycle, hence the -1.
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT - 1);

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    requester_t        r_last_owner;
    requester_t        r_owner;
    logic [ADDR_W-1:0] r_addr;

    logic              w_idle;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_gnt_if;
    logic              w_gnt_d;
    logic              w_start_read;
    logic              w_done;
    logic              w_rv_if;
    logic              w_rv_d;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_idle = (r_state == IDLE);

    // Grants are combinational, so they are also masked while reset is high.
    assign w_req = (w_idle && !reset) ? {bus.d_req, bus.if_req} : 2'b00;

    rr_arbiter_2 u_rr_arbiter_2 (
        .i_req        (w_req),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_gnt)
    );

    assign w_gnt_if     = w_gnt[0];
    assign w_gnt_d      = w_gnt[1];
    assign w_start_read = w_gnt_if | (w_gnt_d & ~bus.d_we);
    assign w_done       = (r_state == READ_WAIT) && (r_cnt == '0);
    assign w_rv_if      = w_done && (r_owner == REQ_IF);
    assign w_rv_d       = w_done && (r_owner == REQ_DATA);
    assign w_mem_rdata  = bus.mem_rdata;

    assign bus.if_gnt    = w_gnt_if;
    assign bus.d_gnt     = w_gnt_d;
    assign bus.if_rvalid = w_rv_if;
    assign bus.d_rvalid  = w_rv_d;

    // Read data is zeroed outside the owner's rvalid so it is never X.
    assign bus.if_rdata = w_rv_if ? w_mem_rdata[31:0] : 32'h0;
    assign bus.d_rdata  = w_rv_d ? w_mem_rdata : '0;

    // The memory command follows the winner in the grant cycle; otherwise the
    // address of the last read is held so the memory sees a stable address
    // for the whole latency window.
    always_comb begin
        bus.mem_addr  = r_addr;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (w_gnt_d) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_we    = bus.d_we;
            bus.mem_wdata = bus.d_wdata;
        end else if (w_gnt_if) begin
            bus.mem_addr  = bus.if_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_owner <= REQ_DATA;
            r_owner      <= REQ_IF;
            r_addr       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_last_owner <= gnt_owner(w_gnt);
                    end
                    if (w_start_read) begin
                        r_state <= READ_WAIT;
                        r_cnt   <= LAT_LOAD;
                        r_owner <= gnt_owner(w_gnt);
                        r_addr  <= w_gnt_d ? bus.d_addr : bus.if_addr;
                    end
                end
                READ_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. u_dut1 runs with
// READ_LAT=1 and is checked through an event scoreboard; u_dut3 runs with
// READ_LAT=3 for the latency and reset-abort cases.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int TMO = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) u_dut3 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus3)
    );

    // Memory model: contents are a fixed function of the address, returned
    // through a READ_LAT-deep pipeline.
    function automatic logic [63:0] mem_f(input logic [63:0] a);
        return {a[31:0] ^ 32'hCAFE_0000, a[31:0] ^ 32'h1234_5678};
    endfunction

    function automatic logic [63:0] lo32(input logic [63:0] a);
        logic [63:0] v;
        v = mem_f(a);
        return {32'h0, v[31:0]};
    endfunction

    logic [DW-1:0] pipe1;
    logic [DW-1:0] pipe3 [0:2];

    always @(posedge clk) begin
        pipe1    <= mem_f(bus1.mem_addr);
        pipe3[0] <= mem_f(bus3.mem_addr);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign bus1.mem_rdata = pipe1;
    assign bus3.mem_rdata = pipe3[2];

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endfunction

    // Scoreboard for u_dut1
    typedef enum logic [2:0] {EV_GNT_IF, EV_GNT_D, EV_WR, EV_RV_IF, EV_RV_D} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [63:0] data;
    } ev_t;

    ev_t exp_q[$];

    function automatic void expect_ev(input ev_kind_t k, input logic [63:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(input ev_kind_t k, input logic [63:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got %s data=%h, required no event", k.name(), d);
            return;
        end
        e = exp_q.pop_front();
        chk({"sb_kind_", e.kind.name()}, 64'(k), 64'(e.kind));
        chk({"sb_data_", e.kind.name()}, d, e.data);
    endfunction

    logic busy1 = 1'b0;
    int   rd_gnt1 = 0;
    int   last_gnt_if1 = -1;
    int   last_gnt_d1 = -1;
    int   last_rv_if1 = -1;
    int   last_rv_d1 = -1;
    int   rv_d_cnt1 = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            busy1 = 1'b0;
        end else begin
            if (bus1.if_gnt || bus1.d_gnt) begin
                chk("gnt_while_read_open", 64'(busy1), 64'd0);
                chk("gnt_both_ports", 64'(bus1.if_gnt & bus1.d_gnt), 64'd0);
            end
            if (bus1.if_gnt) begin
                observe(EV_GNT_IF, bus1.mem_addr);
                last_gnt_if1 = cyc;
                busy1 = 1'b1;
                rd_gnt1 = cyc;
            end
            if (bus1.d_gnt) begin
                observe(EV_GNT_D, bus1.mem_addr);
                last_gnt_d1 = cyc;
                if (!bus1.d_we) begin
                    busy1 = 1'b1;
                    rd_gnt1 = cyc;
                end
            end
            if (bus1.mem_we) observe(EV_WR, bus1.mem_wdata);
            if (bus1.if_rvalid) begin
                observe(EV_RV_IF, {32'h0, bus1.if_rdata});
                chk("lat1_if_gnt_to_rvalid", 64'(cyc - rd_gnt1), 64'd1);
                chk("nonowner_d_rdata", bus1.d_rdata, 64'd0);
                busy1 = 1'b0;
                last_rv_if1 = cyc;
            end
            if (bus1.d_rvalid) begin
                observe(EV_RV_D, bus1.d_rdata);
                chk("lat1_d_gnt_to_rvalid", 64'(cyc - rd_gnt1), 64'd1);
                chk("nonowner_if_rdata", {32'h0, bus1.if_rdata}, 64'd0);
                busy1 = 1'b0;
                last_rv_d1 = cyc;
                rv_d_cnt1++;
            end
        end
    end

    // Recorder for u_dut3
    logic        busy3 = 1'b0;
    int          gnt_busy3 = 0;
    int          g3_if = -1;
    int          g3_d = -1;
    int          rv3_if = -1;
    int          rv3_d = -1;
    int          rv3_if_cnt = 0;
    int          rv3_d_cnt = 0;
    int          we3_cnt = 0;
    logic [63:0] rd3_if = '0;
    logic [63:0] rd3_d = '0;

    initial forever begin
        @(negedge clk);
        if (bus3.d_rvalid) begin
            rv3_d_cnt++;
            rv3_d = cyc;
            rd3_d = bus3.d_rdata;
            busy3 = 1'b0;
        end
        if (bus3.if_rvalid) begin
            rv3_if_cnt++;
            rv3_if = cyc;
            rd3_if = {32'h0, bus3.if_rdata};
            busy3 = 1'b0;
        end
        if (rst) begin
            busy3 = 1'b0;
        end else begin
            if ((bus3.if_gnt || bus3.d_gnt) && busy3) gnt_busy3++;
            if (bus3.if_gnt) begin
                g3_if = cyc;
                busy3 = 1'b1;
            end
            if (bus3.d_gnt) begin
                g3_d = cyc;
                if (!bus3.d_we) busy3 = 1'b1;
            end
            if (bus3.mem_we) we3_cnt++;
        end
    end

    // Drivers
    task automatic set_if(input int sel, input logic r, input logic [63:0] a);
        if (sel == 1) begin
            bus1.if_req  = r;
            bus1.if_addr = a;
        end else begin
            bus3.if_req  = r;
            bus3.if_addr = a;
        end
    endtask

    task automatic set_d(input int sel, input logic r, input logic we, input logic [63:0] a,
                         input logic [63:0] wd);
        if (sel == 1) begin
            bus1.d_req   = r;
            bus1.d_we    = we;
            bus1.d_addr  = a;
            bus1.d_wdata = wd;
        end else begin
            bus3.d_req   = r;
            bus3.d_we    = we;
            bus3.d_addr  = a;
            bus3.d_wdata = wd;
        end
    endtask

    function automatic logic if_gnt_of(input int sel);
        return (sel == 1) ? bus1.if_gnt : bus3.if_gnt;
    endfunction

    function automatic logic d_gnt_of(input int sel);
        return (sel == 1) ? bus1.d_gnt : bus3.d_gnt;
    endfunction

    task automatic do_if(input int sel, input logic [63:0] a, output int waited);
        logic got;
        got = 1'b0;
        waited = 0;
        set_if(sel, 1'b1, a);
        for (int n = 0; n < TMO && !got; n++) begin
            @(negedge clk);
            if (if_gnt_of(sel)) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL if_gnt_timeout: no if_gnt in %0d cycles, required a grant", TMO);
        end
        @(posedge clk);
        #1;
        set_if(sel, 1'b0, 64'h0);
    endtask

    task automatic do_d(input int sel, input logic we, input logic [63:0] a, input logic [63:0] wd,
                        output int waited);
        logic got;
        got = 1'b0;
        waited = 0;
        set_d(sel, 1'b1, we, a, wd);
        for (int n = 0; n < TMO && !got; n++) begin
            @(negedge clk);
            if (d_gnt_of(sel)) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL d_gnt_timeout: no d_gnt in %0d cycles, required a grant", TMO);
        end
        @(posedge clk);
        #1;
        set_d(sel, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int w2;
        int v;

        // Requests are held high during reset: nothing may be granted.
        set_if(1, 1'b1, 64'h80);
        set_d(1, 1'b1, 1'b1, 64'h88, 64'h55);
        set_if(3, 1'b0, 64'h0);
        set_d(3, 1'b0, 1'b0, 64'h0, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_gnt", 64'(bus1.if_gnt), 64'd0);
        chk("rst_d_gnt", 64'(bus1.d_gnt), 64'd0);
        chk("rst_mem_we", 64'(bus1.mem_we), 64'd0);
        set_if(1, 1'b0, 64'h0);
        set_d(1, 1'b0, 1'b0, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_if_rvalid", 64'(bus1.if_rvalid), 64'd0);
        chk("idle_d_rvalid", 64'(bus1.d_rvalid), 64'd0);
        chk("idle_if_rdata_known", 64'($isunknown(bus1.if_rdata)), 64'd0);
        chk("idle_d_rdata_known", 64'($isunknown(bus1.d_rdata)), 64'd0);
        chk("idle_mem_we", 64'(bus1.mem_we), 64'd0);
        @(posedge clk);
        #1;

        // Lone fetch at 0x100: same-cycle grant, rvalid next cycle.
        expect_ev(EV_GNT_IF, 64'h100);
        expect_ev(EV_RV_IF, 64'h0000_0000_1234_5778);
        do_if(1, 64'h100, w);
        chk("t1_if_gnt_wait", 64'(w), 64'd0);
        drain(3);

        // Fetch and load 0x200 together after reset: fetch wins first tie.
        do_reset();
        expect_ev(EV_GNT_IF, 64'h140);
        expect_ev(EV_RV_IF, lo32(64'h140));
        expect_ev(EV_GNT_D, 64'h200);
        expect_ev(EV_RV_D, 64'hCAFE_0200_1234_5478);
        fork
            do_if(1, 64'h140, w);
            do_d(1, 1'b0, 64'h200, 64'h0, w2);
        join
        drain(3);
        chk("t2_d_gnt_after_if_rvalid", 64'(last_gnt_d1 - last_rv_if1), 64'd1);

        // Store then fetch: one write cycle, no d_rvalid, fetch granted next cycle.
        v = rv_d_cnt1;
        expect_ev(EV_GNT_D, 64'h300);
        expect_ev(EV_WR, 64'h0000_0000_DEAD_BEEF);
        expect_ev(EV_GNT_IF, 64'h340);
        expect_ev(EV_RV_IF, lo32(64'h340));
        do_d(1, 1'b1, 64'h300, 64'hDEAD_BEEF, w);
        do_if(1, 64'h340, w2);
        drain(3);
        chk("t3_if_gnt_after_store", 64'(last_gnt_if1 - last_gnt_d1), 64'd1);
        chk("t3_no_store_rvalid", 64'(rv_d_cnt1 - v), 64'd0);

        // Both requesting continuously: IF, D, IF, D, IF, D.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            expect_ev(EV_GNT_IF, 64'h1000 + 64'(16 * i));
            expect_ev(EV_RV_IF, lo32(64'h1000 + 64'(16 * i)));
            expect_ev(EV_GNT_D, 64'h2000 + 64'(8 * i));
            expect_ev(EV_RV_D, mem_f(64'h2000 + 64'(8 * i)));
        end
        fork
            begin
                int wi;
                for (int i = 0; i < 3; i++) do_if(1, 64'h1000 + 64'(16 * i), wi);
            end
            begin
                int wd;
                for (int i = 0; i < 3; i++) do_d(1, 1'b0, 64'h2000 + 64'(8 * i), 64'h0, wd);
            end
        join
        drain(3);

        // Fetch raised while a load is outstanding waits until after d_rvalid.
        expect_ev(EV_GNT_D, 64'h500);
        expect_ev(EV_RV_D, mem_f(64'h500));
        expect_ev(EV_GNT_IF, 64'h540);
        expect_ev(EV_RV_IF, lo32(64'h540));
        fork
            do_d(1, 1'b0, 64'h500, 64'h0, w);
            begin
                @(posedge clk);
                #1;
                do_if(1, 64'h540, w2);
            end
        join
        drain(3);
        chk("t5_if_wait_cycles", 64'(w2), 64'd1);
        chk("t5_if_gnt_after_d_rvalid", 64'(last_gnt_if1 - last_rv_d1), 64'd1);
        chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

        // READ_LAT=3: reset one cycle after d_gnt aborts the load.
        do_reset();
        do_d(3, 1'b0, 64'h600, 64'h0, w);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drain(6);
        chk("lat3_abort_no_d_rvalid", 64'(rv3_d_cnt), 64'd0);
        do_if(3, 64'h680, w);
        chk("lat3_idle_after_abort", 64'(w), 64'd0);
        drain(5);
        chk("lat3_if_latency", 64'(rv3_if - g3_if), 64'd3);
        chk("lat3_if_rdata", rd3_if, lo32(64'h680));
        chk("lat3_if_rvalid_count", 64'(rv3_if_cnt), 64'd1);

        // READ_LAT=3: fetch held off through the whole load latency.
        fork
            do_d(3, 1'b0, 64'h700, 64'h0, w);
            begin
                @(posedge clk);
                #1;
                do_if(3, 64'h740, w2);
            end
        join
        drain(5);
        chk("lat3_d_latency", 64'(rv3_d - g3_d), 64'd3);
        chk("lat3_d_rdata", rd3_d, mem_f(64'h700));
        chk("lat3_if_wait_cycles", 64'(w2), 64'd3);
        chk("lat3_if_gnt_after_d_rvalid", 64'(g3_if - rv3_d), 64'd1);
        chk("lat3_gnt_while_read_open", 64'(gnt_busy3), 64'd0);
        chk("lat3_rvalid_counts", 64'(rv3_if_cnt + rv3_d_cnt), 64'd3);
        chk("lat3_no_writes", 64'(we3_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
